// File: rtl/bound_flasher_param.sv
// Parametrised bound flasher: a WIDTH-LED thermometer bar bounces between bounds
// after a flick, with flick-triggered kick-back, optional auto-repeat and status outputs.
module bound_flasher_param #(
   parameter int WIDTH    = 16,
   parameter int B1       = 5,
   parameter int B2       = 10,
   parameter int STEP_DIV = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flick,
   input  logic             loop,
   output logic [WIDTH-1:0] led,
   output logic [2:0]       state,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   localparam logic [CW-1:0] W_C      = CW'(WIDTH);
   localparam logic [CW-1:0] B1_C     = CW'(B1);
   localparam logic [CW-1:0] B2_C     = CW'(B2);
   localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      UP1  = 3'd1,
      DN1  = 3'd2,
      UP2  = 3'd3,
      DN2  = 3'd4,
      UP3  = 3'd5,
      DN3  = 3'd6,
      KB   = 3'd7
   } state_t;

   state_t           state_r, state_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic [PW-1:0]    pre_r, pre_s;
   logic [WIDTH-1:0] led_r;
   logic             busy_r, done_r, done_s, tick_s;

   function automatic logic [CW-1:0] target(input state_t st);
      case (st)
         UP1:     target = W_C;
         DN1:     target = B1_C;
         UP2:     target = B2_C;
         UP3:     target = B1_C;
         default: target = {CW{1'b0}};
      endcase
   endfunction

   function automatic logic [CW-1:0] step(input state_t st, input logic [CW-1:0] c);
      case (st)
         UP1, UP2, UP3: step = c + CW'(1);
         default:       step = c - CW'(1);
      endcase
   endfunction

   assign tick_s = (state_r != IDLE) && (pre_r == PRE_LAST);

   // Next-state, next-count and prescaler logic; kick-back outranks bound transitions.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      pre_s   = pre_r;
      done_s  = 1'b0;
      if (state_r == IDLE) begin
         pre_s = {PW{1'b0}};
         if (flick) begin
            state_s = UP1;
         end else begin
            state_s = IDLE;
         end
      end else if (!tick_s) begin
         pre_s = pre_r + PW'(1);
      end else begin
         pre_s = {PW{1'b0}};
         if ((state_r == UP1) && ((cnt_r == B1_C) || (cnt_r == B2_C)) && flick) begin
            state_s = KB;
            cnt_s   = cnt_r - CW'(1);
         end else if (cnt_r == target(state_r)) begin
            case (state_r)
               UP1:     state_s = DN1;
               DN1:     state_s = UP2;
               UP2:     state_s = flick ? DN1 : DN2;
               DN2:     state_s = UP3;
               UP3:     state_s = DN3;
               DN3: begin
                  state_s = loop ? UP1 : IDLE;
                  done_s  = 1'b1;
               end
               KB:      state_s = UP1;
               default: state_s = IDLE;
            endcase
            // The new state's step is taken on the same tick, so bounds never dwell.
            cnt_s = (state_s == IDLE) ? {CW{1'b0}} : step(state_s, cnt_r);
         end else begin
            cnt_s = step(state_r, cnt_r);
         end
      end
   end

   // State registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= {CW{1'b0}};
         pre_r   <= {PW{1'b0}};
         led_r   <= {WIDTH{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         pre_r   <= pre_s;
         led_r   <= ~({WIDTH{1'b1}} << cnt_s);
         busy_r  <= (state_s != IDLE);
         done_r  <= done_s;
      end
   end

   assign led   = led_r;
   assign state = state_r;
   assign busy  = busy_r;
   assign done  = done_r;

endmodule

// File: tb/tb_bound_flasher_param.sv
// Bench for bound_flasher_param: a default 16-LED instance and a slow 8-LED instance,
// both tracked by a table-driven model of the bounce sequence.
module tb_bound_flasher_param;

   logic        clk = 1'b0;
   logic        rst_a, flick_a, loop_a, busy_a, done_a;
   logic [15:0] led_a;
   logic [2:0]  state_a;
   logic        rst_b, flick_b, loop_b, busy_b, done_b;
   logic [7:0]  led_b;
   logic [2:0]  state_b;

   int vectors = 0;
   int miscompares = 0;
   int ma_ph = 0, ma_cnt = 0, ma_pre = 0;
   int mb_ph = 0, mb_cnt = 0, mb_pre = 0;
   bit ma_dn = 1'b0, mb_dn = 1'b0;

   always #5 clk = ~clk;

   bound_flasher_param dut_a (
      .clk(clk), .rst(rst_a), .flick(flick_a), .loop(loop_a),
      .led(led_a), .state(state_a), .busy(busy_a), .done(done_a)
   );

   bound_flasher_param #(.WIDTH(8), .B1(2), .B2(5), .STEP_DIV(4)) dut_b (
      .clk(clk), .rst(rst_b), .flick(flick_b), .loop(loop_b),
      .led(led_b), .state(state_b), .busy(busy_b), .done(done_b)
   );

   function automatic logic [15:0] therm_a(input int c);
      logic [31:0] t;
      t = (32'd1 << c) - 32'd1;
      return t[15:0];
   endfunction

   function automatic logic [7:0] therm_b(input int c);
      logic [31:0] t;
      t = (32'd1 << c) - 32'd1;
      return t[7:0];
   endfunction

   // Phase numbers: 0 idle, 1 UP1, 2 DN1, 3 UP2, 4 DN2, 5 UP3, 6 DN3, 7 kick-back.
   task automatic ref_step(input int w, input int b1, input int b2, input int div,
                           input bit fl, input bit lp, input bit rs,
                           inout int ph, inout int cnt, inout int pre, output bit dn);
      int tgt[8];
      int up[8];
      int succ[8];
      int nx;
      tgt  = '{0, w, b1, b2, 0, b1, 0, 0};
      up   = '{0, 1, 0, 1, 0, 1, 0, 0};
      succ = '{0, 2, 3, 4, 5, 6, 0, 1};
      dn = 1'b0;
      if (rs) begin
         ph = 0; cnt = 0; pre = 0;
      end else if (ph == 0) begin
         if (fl) ph = 1;
      end else if (pre != div - 1) begin
         pre = pre + 1;
      end else begin
         pre = 0;
         if (ph == 1 && fl && (cnt == b1 || cnt == b2)) begin
            ph = 7; cnt = cnt - 1;
         end else if (cnt == tgt[ph]) begin
            nx = succ[ph];
            if (ph == 3 && fl) nx = 2;
            if (ph == 6 && lp) nx = 1;
            dn = (ph == 6);
            ph = nx;
            if (ph != 0) cnt = cnt + (up[ph] != 0 ? 1 : -1);
         end else begin
            cnt = cnt + (up[ph] != 0 ? 1 : -1);
         end
      end
   endtask

   task automatic step_clk();
      @(posedge clk);
      ref_step(16, 5, 10, 1, flick_a, loop_a, rst_a, ma_ph, ma_cnt, ma_pre, ma_dn);
      ref_step(8, 2, 5, 4, flick_b, loop_b, rst_b, mb_ph, mb_cnt, mb_pre, mb_dn);
      #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1; flick_a = 1'b1; flick_b = 1'b1;
      loop_a = 1'b0; loop_b = 1'b0;
      step_clk();
      step_clk();
      rst_a = 1'b0; rst_b = 1'b0; flick_a = 1'b0; flick_b = 1'b0;
      vectors++;
      if (state_a !== 3'd0 || led_a !== 16'h0000 || busy_a !== 1'b0 || done_a !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_a: got state=%0d led=%h busy=%b done=%b, want 0 0000 0 0",
                  state_a, led_a, busy_a, done_a);
      end
      vectors++;
      if (state_b !== 3'd0 || led_b !== 8'h00 || busy_b !== 1'b0 || done_b !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_b: got state=%0d led=%h busy=%b done=%b, want 0 00 0 0",
                  state_b, led_b, busy_b, done_b);
      end
   endtask

   // Full pass built from the segment list; noisy adds flick on edges where it is ignored.
   task automatic test_pass(input bit noisy);
      int seg[6][2];
      int exp_q[$];
      int n;
      seg = '{'{1, 16}, '{15, 5}, '{6, 10}, '{9, 0}, '{1, 5}, '{4, 0}};
      for (int s = 0; s < 6; s++) begin
         if (seg[s][0] <= seg[s][1]) for (int v = seg[s][0]; v <= seg[s][1]; v++) exp_q.push_back(v);
         else                        for (int v = seg[s][0]; v >= seg[s][1]; v--) exp_q.push_back(v);
      end
      loop_a = 1'b0; flick_a = 1'b1;
      step_clk();
      flick_a = 1'b0;
      vectors++;
      if (state_a !== 3'd1 || led_a !== 16'h0000 || busy_a !== 1'b1) begin
         miscompares++;
         $display("FAIL pass_start: got state=%0d led=%h busy=%b, want 1 0000 1", state_a, led_a, busy_a);
      end
      for (int k = 0; k < exp_q.size(); k++) begin
         n = k + 1;
         if (noisy && ((n >= 18 && n <= 27) || (n >= 34 && n <= 42) || (n >= 44 && n <= 47) || (n >= 49 && n <= 52)))
            flick_a = 1'($urandom_range(1, 0));
         else
            flick_a = 1'b0;
         step_clk();
         vectors++;
         if (led_a !== therm_a(exp_q[k]) || busy_a !== 1'b1 || done_a !== 1'b0) begin
            miscompares++;
            $display("FAIL pass_edge%0d: got led=%h busy=%b done=%b, want led=%h busy=1 done=0",
                     n, led_a, busy_a, done_a, therm_a(exp_q[k]));
         end
      end
      flick_a = noisy ? 1'b1 : 1'b0;
      step_clk();
      flick_a = 1'b0;
      vectors++;
      if (state_a !== 3'd0 || led_a !== 16'h0000 || busy_a !== 1'b0 || done_a !== 1'b1) begin
         miscompares++;
         $display("FAIL pass_end: got state=%0d led=%h busy=%b done=%b, want 0 0000 0 1",
                  state_a, led_a, busy_a, done_a);
      end
      step_clk();
      vectors++;
      if (state_a !== 3'd0 || done_a !== 1'b0) begin
         miscompares++;
         $display("FAIL pass_done_width: got state=%0d done=%b, want 0 0", state_a, done_a);
      end
   endtask

   task automatic test_kickback_up1();
      flick_a = 1'b1;
      step_clk();
      flick_a = 1'b0;
      for (int i = 0; i < 40 && !(ma_ph == 1 && ma_cnt == 10); i++) step_clk();
      flick_a = 1'b1;
      step_clk();
      flick_a = 1'b0;
      vectors++;
      if (state_a !== 3'd7 || led_a !== therm_a(9)) begin
         miscompares++;
         $display("FAIL kb_up1_enter: got state=%0d led=%h, want 7 %h", state_a, led_a, therm_a(9));
      end
      for (int i = 0; i < 200 && ma_ph != 0; i++) begin
         step_clk();
         vectors++;
         if (state_a !== 3'(ma_ph) || led_a !== therm_a(ma_cnt) || done_a !== ma_dn) begin
            miscompares++;
            $display("FAIL kb_up1_seq: got state=%0d led=%h done=%b, want state=%0d led=%h done=%b",
                     state_a, led_a, done_a, ma_ph, therm_a(ma_cnt), ma_dn);
         end
      end
      vectors++;
      if (state_a !== 3'd0) begin
         miscompares++;
         $display("FAIL kb_up1_timeout: got state=%0d, want 0", state_a);
      end
   endtask

   task automatic test_kickback_up2();
      flick_a = 1'b1;
      step_clk();
      flick_a = 1'b0;
      for (int i = 0; i < 60 && !(ma_ph == 3 && ma_cnt == 10); i++) step_clk();
      flick_a = 1'b1;
      step_clk();
      flick_a = 1'b0;
      vectors++;
      if (state_a !== 3'd2 || led_a !== therm_a(9)) begin
         miscompares++;
         $display("FAIL kb_up2_enter: got state=%0d led=%h, want 2 %h", state_a, led_a, therm_a(9));
      end
      for (int i = 0; i < 20 && !(ma_ph == 3 && ma_cnt == 10); i++) begin
         step_clk();
         vectors++;
         if (state_a !== 3'(ma_ph) || led_a !== therm_a(ma_cnt)) begin
            miscompares++;
            $display("FAIL kb_up2_seq: got state=%0d led=%h, want state=%0d led=%h",
                     state_a, led_a, ma_ph, therm_a(ma_cnt));
         end
      end
      step_clk();
      vectors++;
      if (state_a !== 3'd4 || led_a !== therm_a(9)) begin
         miscompares++;
         $display("FAIL kb_up2_repeat: got state=%0d led=%h, want 4 %h", state_a, led_a, therm_a(9));
      end
      for (int i = 0; i < 60 && ma_ph != 0; i++) step_clk();
      vectors++;
      if (state_a !== 3'd0 || busy_a !== 1'b0) begin
         miscompares++;
         $display("FAIL kb_up2_timeout: got state=%0d busy=%b, want 0 0", state_a, busy_a);
      end
   endtask

   task automatic test_loop_reset();
      loop_a = 1'b1; flick_a = 1'b1;
      step_clk();
      flick_a = 1'b0;
      for (int i = 0; i < 100 && !ma_dn; i++) step_clk();
      vectors++;
      if (state_a !== 3'd1 || led_a !== therm_a(1) || done_a !== 1'b1 || busy_a !== 1'b1) begin
         miscompares++;
         $display("FAIL loop_restart: got state=%0d led=%h done=%b busy=%b, want 1 %h 1 1",
                  state_a, led_a, done_a, busy_a, therm_a(1));
      end
      for (int i = 0; i < 80 && ma_ph != 3; i++) step_clk();
      rst_a = 1'b1;
      step_clk();
      rst_a = 1'b0; loop_a = 1'b0;
      vectors++;
      if (state_a !== 3'd0 || led_a !== 16'h0000 || done_a !== 1'b0 || busy_a !== 1'b0) begin
         miscompares++;
         $display("FAIL loop_midreset: got state=%0d led=%h done=%b busy=%b, want 0 0000 0 0",
                  state_a, led_a, done_a, busy_a);
      end
   endtask

   task automatic test_random_a();
      for (int i = 0; i < 2000; i++) begin
         flick_a = ($urandom_range(3, 0) == 0);
         if ($urandom_range(99, 0) == 0) loop_a = ~loop_a;
         rst_a = ($urandom_range(299, 0) == 0);
         step_clk();
         vectors++;
         if (state_a !== 3'(ma_ph) || led_a !== therm_a(ma_cnt) || busy_a !== (ma_ph != 0) || done_a !== ma_dn) begin
            miscompares++;
            $display("FAIL random_a: got state=%0d led=%h busy=%b done=%b, want state=%0d led=%h busy=%b done=%b",
                     state_a, led_a, busy_a, done_a, ma_ph, therm_a(ma_cnt), ma_ph != 0, ma_dn);
         end
      end
      rst_a = 1'b0; flick_a = 1'b0; loop_a = 1'b0;
   endtask

   task automatic test_step_div();
      int cycles;
      rst_b = 1'b1;
      step_clk();
      rst_b = 1'b0; loop_b = 1'b0; flick_b = 1'b1;
      step_clk();
      flick_b = 1'b0;
      cycles = 0;
      for (int i = 0; i < 300 && done_b !== 1'b1; i++) begin
         step_clk();
         cycles++;
         vectors++;
         if (state_b !== 3'(mb_ph) || led_b !== therm_b(mb_cnt) || done_b !== mb_dn) begin
            miscompares++;
            $display("FAIL div_seq: got state=%0d led=%h done=%b, want state=%0d led=%h done=%b",
                     state_b, led_b, done_b, mb_ph, therm_b(mb_cnt), mb_dn);
         end
      end
      vectors++;
      if (cycles != 108) begin
         miscompares++;
         $display("FAIL div_pass_len: got %0d cycles, want 108", cycles);
      end
      step_clk();
      vectors++;
      if (done_b !== 1'b0 || state_b !== 3'd0) begin
         miscompares++;
         $display("FAIL div_done_width: got done=%b state=%0d, want 0 0", done_b, state_b);
      end
      for (int i = 0; i < 1500; i++) begin
         flick_b = ($urandom_range(3, 0) == 0);
         if ($urandom_range(99, 0) == 0) loop_b = ~loop_b;
         rst_b = ($urandom_range(399, 0) == 0);
         step_clk();
         vectors++;
         if (state_b !== 3'(mb_ph) || led_b !== therm_b(mb_cnt) || busy_b !== (mb_ph != 0) || done_b !== mb_dn) begin
            miscompares++;
            $display("FAIL random_b: got state=%0d led=%h busy=%b done=%b, want state=%0d led=%h busy=%b done=%b",
                     state_b, led_b, busy_b, done_b, mb_ph, therm_b(mb_cnt), mb_ph != 0, mb_dn);
         end
      end
   endtask

   initial begin
      test_reset();
      test_pass(1'b0);
      test_pass(1'b1);
      test_kickback_up1();
      test_kickback_up2();
      test_loop_reset();
      test_random_a();
      test_step_div();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
